dmem_rsp: RTL and testbench

- Responder end of the data-memory request interface driven by the memory-control stage: accepts read/write requests, returns word read data, commits word writes.
- Inserts a configurable number of wait states. Stalls the initiator through a hold flag and reports completion and out-of-range errors.
- Sits between the memory-control stage and the on-chip data RAM.
- Byte/halfword merging stays in the initiator. This block only ever moves whole 32-bit words.

---
 rtl/dmem_rsp_pkg.sv | 24 ++
 rtl/dmem_rsp_array.sv | 24 ++
 rtl/dmem_rsp.sv | 109 ++++++++++
 tb/tb_dmem_rsp.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_rsp_pkg.sv
// Shared bus types, control constants and FSM encodings for the data-memory responder.
package dmem_rsp_pkg;

  typedef logic [31:0] MemBus;
  typedef logic [31:0] MemAddrBus;

  localparam logic RIB_REQ      = 1'b1;
  localparam logic RIB_NREQ     = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic HoldEnable   = 1'b1;
  localparam logic HoldDisable  = 1'b0;

  localparam MemBus ZeroWord = 32'h0000_0000;

  localparam logic [0:0] DMEM_IDLE = 1'b0;
  localparam logic [0:0] DMEM_WAIT = 1'b1;

  // True when the word address (addr[31:2]) falls inside a depth-word array.
  function automatic logic word_in_range(input MemAddrBus addr, input int unsigned depth);
    return (addr >> 2) < depth;
  endfunction

endpackage

// File: rtl/dmem_rsp_array.sv
// Word storage for dmem_rsp: combinational read, synchronous write, no reset on contents.
module dmem_array
  import dmem_rsp_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  MemBus         wdata,
  input  logic [AW-1:0] raddr,
  output MemBus         rdata
);

  MemBus mem [DEPTH_WORDS];

  assign rdata = mem[raddr];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/dmem_rsp.sv
// Data-memory responder: wait-state FSM, range checking, ack/err pulses over dmem_array.
// Optional DMEM_STAT_EN adds committed read/write counters rd_cnt_o / wr_cnt_o.
module dmem_rsp
  import dmem_rsp_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_CYCLES = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      mem_req_i,
  input  logic      mem_we_i,
  input  MemAddrBus mem_raddr_i,
  input  MemAddrBus mem_waddr_i,
  input  MemBus     mem_wdata_i,
  output MemBus     mem_rdata_o,
  output logic      hold_flag_o,
  output logic      mem_ack_o,
  output logic      mem_err_o
`ifdef DMEM_STAT_EN
  ,
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [0:0] state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       commit;
  logic       rd_ok, wr_ok;
  MemBus      rd_word;

  assign rd_ok = word_in_range(mem_raddr_i, DEPTH_WORDS);
  assign wr_ok = word_in_range(mem_waddr_i, DEPTH_WORDS);

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (commit & mem_we_i & wr_ok),
    .waddr(mem_waddr_i[AW+1:2]),
    .wdata(mem_wdata_i),
    .raddr(mem_raddr_i[AW+1:2]),
    .rdata(rd_word)
  );

  assign mem_rdata_o = rd_ok ? rd_word : ZeroWord;

  // Hold and commit are gated by rst so outputs drop the moment reset asserts.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    commit      = 1'b0;
    hold_flag_o = HoldDisable;
    if (!rst) begin
      if (state == DMEM_IDLE) begin
        if (mem_req_i == RIB_REQ) begin
          if (WAIT_CYCLES == 0) begin
            commit = 1'b1;
          end else begin
            hold_flag_o = HoldEnable;
            cnt_nxt     = WAIT_LOAD;
            state_nxt   = DMEM_WAIT;
          end
        end
      end else begin
        if (mem_req_i == RIB_NREQ) begin
          state_nxt = DMEM_IDLE;
        end else if (cnt != 4'd0) begin
          hold_flag_o = HoldEnable;
          cnt_nxt     = cnt - 4'd1;
        end else begin
          commit    = 1'b1;
          state_nxt = DMEM_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DMEM_IDLE;
      cnt       <= 4'd0;
      mem_ack_o <= 1'b0;
      mem_err_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mem_ack_o <= commit;
      mem_err_o <= commit & ((mem_we_i == WriteEnable) ? !wr_ok : !rd_ok);
    end
  end

`ifdef DMEM_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_o <= 32'd0;
      wr_cnt_o <= 32'd0;
    end else if (commit) begin
      if (mem_we_i == WriteEnable) wr_cnt_o <= wr_cnt_o + 32'd1;
      else                         rd_cnt_o <= rd_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_rsp.sv
// Bench for dmem_rsp: a zero-wait 16-word instance and a 3-wait 64-word instance against a word-array model.
module tb_dmem_rsp;

  logic        clk = 1'b0;
  logic        rst;
  logic        req [2];
  logic        we  [2];
  logic [31:0] ra  [2];
  logic [31:0] wa  [2];
  logic [31:0] wd  [2];
  logic [31:0] rd  [2];
  logic        hold[2];
  logic        ack [2];
  logic        err [2];
`ifdef DMEM_STAT_EN
  logic [31:0] rdc [2];
  logic [31:0] wrc [2];
  int unsigned rd_n[2];
  int unsigned wr_n[2];
`endif

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] mdl [2][64];
  bit last_ack[2];
  bit last_err[2];

  dmem_rsp #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_fast (
    .clk(clk), .rst(rst), .mem_req_i(req[0]), .mem_we_i(we[0]),
    .mem_raddr_i(ra[0]), .mem_waddr_i(wa[0]), .mem_wdata_i(wd[0]),
    .mem_rdata_o(rd[0]), .hold_flag_o(hold[0]), .mem_ack_o(ack[0]), .mem_err_o(err[0])
`ifdef DMEM_STAT_EN
    , .rd_cnt_o(rdc[0]), .wr_cnt_o(wrc[0])
`endif
  );

  dmem_rsp #(.DEPTH_WORDS(64), .WAIT_CYCLES(3)) u_slow (
    .clk(clk), .rst(rst), .mem_req_i(req[1]), .mem_we_i(we[1]),
    .mem_raddr_i(ra[1]), .mem_waddr_i(wa[1]), .mem_wdata_i(wd[1]),
    .mem_rdata_o(rd[1]), .hold_flag_o(hold[1]), .mem_ack_o(ack[1]), .mem_err_o(err[1])
`ifdef DMEM_STAT_EN
    , .rd_cnt_o(rdc[1]), .wr_cnt_o(wrc[1])
`endif
  );

  always #5 clk = ~clk;

  function automatic int dep(input int i);
    return (i == 0) ? 16 : 64;
  endfunction

  function automatic int wt(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic bit oor(input int i, input logic [31:0] a);
    return (a >> 2) >= 32'(dep(i));
  endfunction

  function automatic logic [31:0] mdl_rd(input int i, input logic [31:0] a);
    if (oor(i, a)) return 32'h0;
    return mdl[i][a[7:2]];
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One request on instance i; abort_at >= 1 drops the request in that WAIT cycle.
  task automatic run_txn(input int i, input bit w_e, input logic [31:0] r_a,
                         input logic [31:0] w_a, input logic [31:0] w_d, input int abort_at);
    int w;
    bit aborted;
    w = wt(i);
    aborted = 1'b0;
    req[i] = 1'b1; we[i] = w_e; ra[i] = r_a; wa[i] = w_a; wd[i] = w_d;
    for (int k = 0; k <= w; k++) begin
      if (k == abort_at) begin
        req[i] = 1'b0;
        aborted = 1'b1;
      end
      @(negedge clk);
      chk_eq($sformatf("hold%0d", i), 32'(hold[i]), 32'(!aborted && k < w));
      chk_eq($sformatf("rdata%0d", i), rd[i], mdl_rd(i, r_a));
      chk_eq($sformatf("ack%0d", i), 32'(ack[i]), (k == 0) ? 32'(last_ack[i]) : 32'd0);
      chk_eq($sformatf("err%0d", i), 32'(err[i]), (k == 0) ? 32'(last_err[i]) : 32'd0);
      @(posedge clk); #1;
      if (aborted) break;
    end
    if (aborted) begin
      last_ack[i] = 1'b0;
      last_err[i] = 1'b0;
    end else begin
      last_ack[i] = 1'b1;
      last_err[i] = w_e ? oor(i, w_a) : oor(i, r_a);
      if (w_e && !oor(i, w_a)) mdl[i][w_a[7:2]] = w_d;
`ifdef DMEM_STAT_EN
      if (w_e) wr_n[i]++;
      else     rd_n[i]++;
`endif
    end
  endtask

  task automatic idle_cycle(input int i);
    req[i] = 1'b0;
    @(negedge clk);
    chk_eq($sformatf("idle_hold%0d", i), 32'(hold[i]), 32'd0);
    chk_eq($sformatf("idle_ack%0d", i), 32'(ack[i]), 32'(last_ack[i]));
    chk_eq($sformatf("idle_err%0d", i), 32'(err[i]), 32'(last_err[i]));
    chk_eq($sformatf("idle_rdata%0d", i), rd[i], mdl_rd(i, ra[i]));
    @(posedge clk); #1;
    last_ack[i] = 1'b0;
    last_err[i] = 1'b0;
  endtask

`ifdef DMEM_STAT_EN
  task automatic chk_stats();
    for (int i = 0; i < 2; i++) begin
      chk_eq($sformatf("rd_cnt%0d", i), rdc[i], rd_n[i]);
      chk_eq($sformatf("wr_cnt%0d", i), wrc[i], wr_n[i]);
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b, v;
    int i, ab;
    rst = 1'b1;
    for (int j = 0; j < 2; j++) begin
      req[j] = 1'b0; we[j] = 1'b0; ra[j] = 32'h0; wa[j] = 32'h0; wd[j] = 32'h0;
      last_ack[j] = 1'b0; last_err[j] = 1'b0;
`ifdef DMEM_STAT_EN
      rd_n[j] = 0; wr_n[j] = 0;
`endif
    end
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      chk_eq($sformatf("rst_hold%0d", j), 32'(hold[j]), 32'd0);
      chk_eq($sformatf("rst_ack%0d", j), 32'(ack[j]), 32'd0);
      chk_eq($sformatf("rst_err%0d", j), 32'(err[j]), 32'd0);
    end
`ifdef DMEM_STAT_EN
    chk_stats();
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // Give every word a known value.
    for (int j = 0; j < 2; j++) begin
      for (int w = 0; w < dep(j); w++) run_txn(j, 1'b1, 32'h0, 32'(w * 4), $urandom, -1);
      idle_cycle(j);
    end

    // Zero-wait write then back-to-back read of the same word.
    run_txn(0, 1'b1, 32'h10, 32'h10, 32'hDEADBEEF, -1);
    run_txn(0, 1'b0, 32'h10, 32'h0, 32'h0, -1);
    idle_cycle(0);
    // Last in-range word, then out-of-range write and read on the 16-word array.
    run_txn(0, 1'b1, 32'h3C, 32'h3C, 32'h0BAD_F00D, -1);
    run_txn(0, 1'b1, 32'h44, 32'h40, 32'h5555_AAAA, -1);
    run_txn(0, 1'b0, 32'h44, 32'h0, 32'h0, -1);
    idle_cycle(0);

    // Three wait states: old word visible while holding, new word afterwards.
    run_txn(1, 1'b1, 32'h20, 32'h20, 32'h12345678, -1);
    idle_cycle(1);
    // Store merge: read-modify-write of byte 1.
    run_txn(1, 1'b1, 32'h40, 32'h40, 32'hAABBCCDD, -1);
    idle_cycle(1);
    v = (mdl_rd(1, 32'h40) & 32'hFFFF_00FF) | 32'h0000_1100;
    run_txn(1, 1'b1, 32'h40, 32'h40, v, -1);
    idle_cycle(1);
    // Abort in WAIT: no commit, no ack.
    run_txn(1, 1'b1, 32'h24, 32'h24, 32'hCAFE_F00D, 2);
    idle_cycle(1);
    run_txn(1, 1'b0, 32'h24, 32'h0, 32'h0, -1);
    idle_cycle(1);

    // Reset in the middle of a wait: outputs drop at once, write is lost.
    req[1] = 1'b1; we[1] = 1'b1; ra[1] = 32'h28; wa[1] = 32'h28; wd[1] = 32'hFEED_0001;
    @(negedge clk);
    chk_eq("midrst_hold_before", 32'(hold[1]), 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk_eq("midrst_hold", 32'(hold[1]), 32'd0);
    chk_eq("midrst_ack", 32'(ack[1]), 32'd0);
    chk_eq("midrst_err", 32'(err[1]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    req[1] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      last_ack[j] = 1'b0; last_err[j] = 1'b0;
`ifdef DMEM_STAT_EN
      rd_n[j] = 0; wr_n[j] = 0;
`endif
    end
`ifdef DMEM_STAT_EN
    chk_stats();
`endif
    run_txn(1, 1'b0, 32'h28, 32'h0, 32'h0, -1);
    idle_cycle(1);

    // Randomized traffic, with occasional back-to-back requests and aborts.
    for (int blk = 0; blk < 2; blk++) begin
      i = blk;
      for (int n = 0; n < 60; n++) begin
        a = 32'($urandom_range(0, dep(i) + 3) * 4) | 32'($urandom_range(0, 3));
        b = ($urandom_range(0, 1) == 1) ? a
            : (32'($urandom_range(0, dep(i) + 3) * 4) | 32'($urandom_range(0, 3)));
        if ($urandom_range(0, 15) == 0) a = {1'b1, 31'($urandom)};
        ab = (wt(i) > 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, wt(i))) : -1;
        run_txn(i, 1'($urandom_range(0, 1)), b, a, $urandom, ab);
        if ($urandom_range(0, 1) == 1) idle_cycle(i);
      end
      idle_cycle(i);
    end

`ifdef DMEM_STAT_EN
    chk_stats();
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int j = 0; j < 2; j++) begin rd_n[j] = 0; wr_n[j] = 0; end
    chk_stats();
    @(posedge clk); #1;
    rst = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
